// File: rtl/icache_assoc_ctlr.sv
// Set-associative L1 instruction cache controller: hit/miss qualification,
// branch-aware replacement gating, victim choice, multi-beat refill and fence.i.
module icache_assoc_ctlr #(
  parameter int         S          = 64,
  parameter int         E          = 4,
  parameter int         B          = 16,
  parameter int         D          = 1,
  parameter logic [1:0] NON_BRANCH = 2'b00
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [$clog2(S)-1:0] set_i,
  input  logic [E-1:0]         hit_way_i,
  input  logic [1:0]           pc_src_reg_i,
  input  logic [1:0]           branch_op_e_i,
  input  logic                 invalidate_i,
  input  logic                 mem_ack_i,
  input  logic                 mem_valid_i,
  output logic [E-1:0]         valid_o,
  output logic                 instr_miss_f_o,
  output logic                 instr_cache_rep_active_o,
  output logic                 mem_req_o,
  output logic [$clog2(S)-1:0] mem_set_o,
  output logic [E-1:0]         fill_en_o,
  output logic [$clog2(B)-1:0] fill_word_o,
  output logic                 fill_done_o,
  output logic                 busy_o
);

  localparam int SW = $clog2(S);
  localparam int EW = $clog2(E);
  localparam int BW = $clog2(B);
  localparam int DW = $clog2(D + 1);

  // state  | meaning
  // IDLE   | serving hits, waiting for a miss that may be replaced
  // REQ    | refill request outstanding until memory acks
  // FILL   | writing one beat per mem_valid_i into the victim way
  // DONE   | line complete: mark valid, advance round-robin
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [E-1:0]    valid_q [S];
  logic [E-1:0]    valid_d [S];
  logic [EW-1:0]   rr_q [S];
  logic [EW-1:0]   rr_d [S];
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [SW-1:0]   set_q, set_d;
  logic [E-1:0]    victim_q, victim_d;
  logic            inv_pend_q, inv_pend_d;

  logic            hit;
  logic            redirect;
  logic            dly_expired;
  logic            rep_active;
  logic            clear_all;
  logic [EW-1:0]   vic_idx;
  logic            pc_src_unused;

  assign pc_src_unused = pc_src_reg_i[0];

  // Hit qualification and replacement gating
  assign hit         = |(hit_way_i & valid_q[set_i]);
  assign redirect    = pc_src_reg_i[1];
  assign dly_expired = (dly_q == DW'(D));
  assign rep_active  = ((branch_op_e_i == NON_BRANCH) | hit | dly_expired) & ~redirect;

  assign valid_o                  = valid_q[set_i];
  assign instr_miss_f_o           = ~hit;
  assign instr_cache_rep_active_o = rep_active;
  assign mem_set_o                = set_q;
  assign fill_word_o              = cnt_q;
  assign busy_o                   = (state_q != ST_IDLE);

  // Victim: lowest invalid way of the fetch set, else the set's round-robin way
  always_comb begin
    vic_idx = rr_q[set_i];
    for (int w = E - 1; w >= 0; w--) begin
      if (!valid_q[set_i][w]) vic_idx = EW'(w);
    end
  end

  // Next-state, refill datapath and output decode
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    set_d       = set_q;
    victim_d    = victim_q;
    inv_pend_d  = inv_pend_q;
    clear_all   = 1'b0;
    mem_req_o   = 1'b0;
    fill_en_o   = '0;
    fill_done_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        inv_pend_d = 1'b0;
        if (hit || redirect) dly_d = '0;
        else if (!rep_active) dly_d = dly_q + DW'(1);
        if (invalidate_i) begin
          clear_all = 1'b1;
        end else if (!hit && rep_active) begin
          state_d  = ST_REQ;
          set_d    = set_i;
          victim_d = E'(1) << vic_idx;
          dly_d    = '0;
        end
      end
      ST_REQ: begin
        mem_req_o = 1'b1;
        if (invalidate_i) inv_pend_d = 1'b1;
        // An ack wins over a same-cycle redirect: memory has committed to the line.
        if (mem_ack_i) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else if (redirect) begin
          state_d    = ST_IDLE;
          clear_all  = inv_pend_q | invalidate_i;
          inv_pend_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (invalidate_i) inv_pend_d = 1'b1;
        if (mem_valid_i) begin
          fill_en_o = victim_q;
          cnt_d     = cnt_q + BW'(1);
          if (cnt_q == BW'(B - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fill_done_o      = 1'b1;
        valid_d[set_q]   = valid_q[set_q] | victim_q;
        if (victim_q == (E'(1) << rr_q[set_q])) rr_d[set_q] = rr_q[set_q] + EW'(1);
        clear_all        = inv_pend_q | invalidate_i;
        inv_pend_d       = 1'b0;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so a line filled in the same cycle is dropped too
    if (clear_all) begin
      for (int s = 0; s < S; s++) valid_d[s] = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dly_q      <= '0;
      set_q      <= '0;
      victim_q   <= '0;
      inv_pend_q <= 1'b0;
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      set_q      <= set_d;
      victim_q   <= victim_d;
      inv_pend_q <= inv_pend_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
    end
  end

endmodule
